uart_rx_os: RTL and testbench

Parametrised oversampling UART receiver, the next generation of the fixed 8-bit receiver. It synchronises the asynchronous rx line and samples each bit three times around mid-bit with a majority vote. Data width, parity mode and stop-bit count are set by parameters. It flags parity errors, framing errors and line breaks, and delivers each frame as a one-cycle valid pulse to downstream protocol logic.

---
 rtl/uart_rx_os.sv | 116 +++++++++++
 tb/tb_uart_rx_os.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with a 2-of-3 mid-bit vote,
// parametrised framing and parity/framing/break reporting.
module uart_rx_os #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_vld,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 busy
);
   localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE) - 1;
   localparam int DW = $clog2(TICK_DIV + 2);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int M = OVERSAMPLE / 2;
   localparam logic [DW-1:0] TD = DW'(TICK_DIV);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_V0 = SW'(M - 1);
   localparam logic [SW-1:0] S_V1 = SW'(M);
   localparam logic [SW-1:0] S_V2 = SW'(M + 1);
   localparam logic [3:0] D_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0] P_LAST = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_DONE, S_WAIT} state_t;
   state_t state, state_nx;

   logic rx_m, rx_s, rx_p;
   logic [DW-1:0] div;
   logic [SW-1:0] smp;
   logic [3:0] cnt;
   logic v0, v1, fe, low, pbad;
   logic [DATA_BITS-1:0] sh;
   logic hold, tick, bit_end, vote_t, vote, p_exp;

   // counters sit at zero through IDLE so the first bit is timed from the start edge
   assign hold    = state == S_IDLE || state_nx == S_IDLE;
   assign tick    = state != S_IDLE && div == TD;
   assign bit_end = tick && smp == S_LAST;
   assign vote_t  = tick && smp == S_V2;
   assign vote    = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
   assign p_exp   = PARITY == 1 ? ~^sh : ^sh;
   assign busy    = state != S_IDLE;

   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) {rx_m, rx_s, rx_p} <= 3'b111;
      else {rx_m, rx_s, rx_p} <= {rx, rx_m, rx_s};

   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) state <= S_IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (rx_p && !rx_s) state_nx = S_START;
         S_START: state_nx = (vote_t && vote) ? S_IDLE : bit_end ? S_DATA : S_START;
         S_DATA:  if (bit_end && cnt == D_LAST) state_nx = PARITY != 0 ? S_PAR : S_STOP;
         S_PAR:   if (bit_end) state_nx = S_STOP;
         // leave at the last stop vote, not bit end, so a back-to-back start edge is seen
         S_STOP:  if (vote_t && cnt == P_LAST) state_nx = S_DONE;
         S_DONE:  state_nx = fe ? S_WAIT : S_IDLE;
         S_WAIT:  if (rx_s) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         div        <= '0;
         smp        <= '0;
         cnt        <= '0;
         v0         <= 1'b0;
         v1         <= 1'b0;
         fe         <= 1'b0;
         low        <= 1'b0;
         pbad       <= 1'b0;
         sh         <= '0;
         rx_data    <= '0;
         rx_vld     <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         break_det  <= 1'b0;
      end else begin
         div <= hold ? '0 : (div == TD ? '0 : div + 1'b1);
         smp <= hold ? '0 : (tick ? (smp == S_LAST ? '0 : smp + 1'b1) : smp);
         cnt <= state_nx != state ? '0 : (bit_end ? cnt + 4'd1 : cnt);
         if (tick && smp == S_V0) v0 <= rx_s;
         if (tick && smp == S_V1) v1 <= rx_s;
         if (state == S_IDLE) begin
            fe   <= 1'b0;
            low  <= 1'b1;
            pbad <= 1'b0;
         end else if (vote_t) begin
            low <= low & ~vote;
            if (state == S_DATA) sh <= {vote, sh[DATA_BITS-1:1]};
            if (state == S_PAR) pbad <= vote != p_exp;
            if (state == S_STOP && !vote) fe <= 1'b1;
         end
         rx_vld <= state == S_DONE;
         if (state == S_DONE) begin
            rx_data    <= sh;
            parity_err <= pbad;
            frame_err  <= fe;
            break_det  <= low;
         end
      end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: four receiver configurations driven with random and directed
// frames, checked against a frame-level decoding model.
module tb_uart_rx_os;
   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   logic [3:0] rx_l = '1;
   logic [3:0] vld, pe, fe, bd, bz;
   logic [7:0] d0, d1;
   logic [6:0] d2;
   logic [8:0] d3;

   always #5 sys_clk = ~sys_clk;

   uart_rx_os u0 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_l[0]), .rx_data(d0), .rx_vld(vld[0]),
                  .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bd[0]), .busy(bz[0]));
   uart_rx_os #(.CLK_FREQ(3_686_400), .OVERSAMPLE(8), .PARITY(2)) u1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_l[1]), .rx_data(d1), .rx_vld(vld[1]),
      .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bd[1]), .busy(bz[1]));
   uart_rx_os #(.CLK_FREQ(3_686_400), .OVERSAMPLE(8), .DATA_BITS(7), .STOP_BITS(2)) u2 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_l[2]), .rx_data(d2), .rx_vld(vld[2]),
      .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bd[2]), .busy(bz[2]));
   uart_rx_os #(.CLK_FREQ(3_686_400), .OVERSAMPLE(8), .DATA_BITS(9), .PARITY(1)) u3 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_l[3]), .rx_data(d3), .rx_vld(vld[3]),
      .parity_err(pe[3]), .frame_err(fe[3]), .break_det(bd[3]), .busy(bz[3]));

   int DB [4] = '{8, 8, 7, 9};
   int PAR [4] = '{0, 2, 0, 1};
   int SB [4] = '{1, 1, 2, 1};
   int BIT [4] = '{432, 32, 32, 32};

   typedef struct {
      int         inst;
      logic [8:0] data;
      logic       pe;
      logic       fe;
      logic       bd;
   } exp_t;

   exp_t q[$];
   exp_t last_exp [4];
   exp_t me;
   int n_chk = 0, n_pass = 0, cyc = 0;
   int vld_cnt [4] = '{0, 0, 0, 0};
   int vld_cyc [4] = '{0, 0, 0, 0};
   logic [3:0] vld_p = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [8:0] gd(input int i);
      case (i)
         0: return {1'b0, d0};
         1: return {1'b0, d1};
         2: return {2'b0, d2};
         default: return d3;
      endcase
   endfunction

   function automatic int flen(input int i);
      return 1 + DB[i] + int'(PAR[i] != 0) + SB[i];
   endfunction

   // line bits of one frame, bit 0 first on the wire
   function automatic logic [31:0] mk(input int i, input logic [8:0] d, input bit pflip, input bit stop_low);
      logic [31:0] f = '0;
      logic [8:0] dm = '0;
      for (int k = 0; k < DB[i]; k++) begin
         dm[k] = d[k];
         f[1+k] = d[k];
      end
      if (PAR[i] != 0) f[1+DB[i]] = (PAR[i] == 1 ? ~^dm : ^dm) ^ pflip;
      for (int s = 0; s < SB[i]; s++) f[1+DB[i]+int'(PAR[i] != 0)+s] = !stop_low;
      return f;
   endfunction

   // what a receiver must report for a frame of line bits
   function automatic exp_t model(input int i, input logic [31:0] f);
      exp_t e;
      int pb = 1 + DB[i];
      e.inst = i;
      e.data = '0;
      e.fe = 1'b0;
      e.bd = 1'b1;
      for (int k = 0; k < DB[i]; k++) e.data[k] = f[1+k];
      e.pe = (PAR[i] != 0) && (f[pb] != (PAR[i] == 1 ? ~^e.data : ^e.data));
      for (int s = 0; s < SB[i]; s++) if (!f[pb+int'(PAR[i] != 0)+s]) e.fe = 1'b1;
      for (int k = 0; k < flen(i); k++) if (f[k]) e.bd = 1'b0;
      return e;
   endfunction

   task automatic push(input int i, input logic [8:0] d, input logic p, input logic f, input logic b);
      exp_t e;
      e.inst = i;
      e.data = d;
      e.pe = p;
      e.fe = f;
      e.bd = b;
      q.push_back(e);
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(posedge sys_clk);
   endtask

   task automatic send(input int i, input logic [31:0] f, input int n);
      for (int k = 0; k < n; k++) begin
         rx_l[i] = f[k];
         clk_n(BIT[i]);
      end
   endtask

   task automatic idle(input int i, input int bits);
      rx_l[i] = 1'b1;
      clk_n(bits * BIT[i]);
   endtask

   task automatic drain(input int i);
      int k = 0;
      while (q.size() != 0 && k < 4 * BIT[i]) begin
         @(posedge sys_clk);
         k++;
      end
      chk("vld_timeout", q.size(), 0);
      q.delete();
   endtask

   always @(posedge sys_clk) cyc++;

   always @(negedge sys_clk) begin
      for (int i = 0; i < 4; i++)
         if (vld[i]) begin
            vld_cnt[i]++;
            vld_cyc[i] = cyc;
            chk("vld_width", 32'(vld_p[i]), 0);
            if (q.size() == 0 || q[0].inst != i) chk("unexpected_vld", 1, 0);
            else begin
               me = q.pop_front();
               chk("rx_data", gd(i), me.data);
               chk("parity_err", pe[i], me.pe);
               chk("frame_err", fe[i], me.fe);
               chk("break_det", bd[i], me.bd);
               last_exp[i] = me;
            end
         end
      vld_p = vld;
   end

   initial begin
      logic [31:0] f;
      int vc, t0, mid, gap, nf;
      bit seen, sl;
      for (int i = 0; i < 4; i++) last_exp[i] = '{i, 9'h0, 1'b0, 1'b0, 1'b0};
      clk_n(5);
      @(negedge sys_clk);
      chk("rst_data0", d0, 0);
      chk("rst_data3", d3, 0);
      chk("rst_vld", vld, 0);
      chk("rst_flags", {pe, fe, bd}, 0);
      chk("rst_busy", bz, 0);
      sys_rst_n = 1'b1;
      clk_n(5);

      // default 8N1 frame plus latency from the stop-bit midpoint
      push(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
      vc = vld_cnt[0];
      t0 = cyc;
      send(0, mk(0, 9'h0A5, 1'b0, 1'b0), 10);
      idle(0, 2);
      drain(0);
      mid = t0 + 9 * BIT[0] + BIT[0] / 2;
      chk("vld_latency", 32'(vld_cyc[0] >= mid && vld_cyc[0] <= mid + BIT[0]), 1);
      chk("one_vld", vld_cnt[0] - vc, 1);

      // even parity: 0x03 with parity bit 1 then 0
      push(1, 9'h003, 1'b1, 1'b0, 1'b0);
      send(1, 32'h606, 11);
      idle(1, 2);
      push(1, 9'h003, 1'b0, 1'b0, 1'b0);
      send(1, 32'h406, 11);
      idle(1, 2);
      drain(1);

      // glitch shorter than a half bit is a false start
      vc = vld_cnt[0];
      seen = 1'b0;
      rx_l[0] = 1'b0;
      for (int k = 0; k < 2 * BIT[0]; k++) begin
         @(posedge sys_clk);
         if (k == 2) rx_l[0] = 1'b1;
         @(negedge sys_clk);
         if (bz[0]) seen = 1'b1;
      end
      chk("fs_busy_seen", seen, 1);
      chk("fs_busy_end", bz[0], 0);
      chk("fs_no_vld", vld_cnt[0] - vc, 0);
      chk("fs_data_hold", d0, last_exp[0].data);
      chk("fs_flags_hold", {pe[0], fe[0], bd[0]}, {last_exp[0].pe, last_exp[0].fe, last_exp[0].bd});

      // stop bit low, line released two bit times later
      vc = vld_cnt[0];
      push(0, 9'h05A, 1'b0, 1'b1, 1'b0);
      send(0, mk(0, 9'h05A, 1'b0, 1'b1), 11);
      @(negedge sys_clk);
      chk("fe_busy_low", bz[0], 1);
      chk("fe_one_vld", vld_cnt[0] - vc, 1);
      idle(0, 2);
      chk("fe_busy_rel", bz[0], 0);
      drain(0);

      // long break reports once
      vc = vld_cnt[0];
      push(0, 9'h000, 1'b0, 1'b1, 1'b1);
      send(0, 32'h0, 20);
      @(negedge sys_clk);
      chk("brk_busy_low", bz[0], 1);
      chk("brk_one_vld", vld_cnt[0] - vc, 1);
      idle(0, 2);
      chk("brk_busy_rel", bz[0], 0);
      chk("brk_still_one", vld_cnt[0] - vc, 1);
      drain(0);
      q.push_back(model(3, 32'h0));
      send(3, 32'h0, 15);
      idle(3, 2);
      drain(3);

      // random frames on every configuration
      for (int i = 0; i < 4; i++) begin
         nf = i == 0 ? 3 : 25;
         for (int n = 0; n < nf; n++) begin
            sl = $urandom_range(0, 7) == 0;
            f = mk(i, 9'($urandom), PAR[i] != 0 && $urandom_range(0, 3) == 0, sl);
            q.push_back(model(i, f));
            send(i, f, flen(i));
            gap = sl ? 1 + $urandom_range(0, 1) : $urandom_range(0, 1);
            if (gap != 0) idle(i, gap);
         end
         idle(i, 2);
         drain(i);
      end

      // 7-bit, two stop bits, back to back
      push(2, 9'h07F, 1'b0, 1'b0, 1'b0);
      push(2, 9'h000, 1'b0, 1'b0, 1'b0);
      push(2, 9'h041, 1'b0, 1'b0, 1'b0);
      send(2, mk(2, 9'h07F, 1'b0, 1'b0), 10);
      send(2, mk(2, 9'h000, 1'b0, 1'b0), 10);
      send(2, mk(2, 9'h041, 1'b0, 1'b0), 10);
      idle(2, 2);
      drain(2);

      // reset in the middle of a frame
      vc = vld_cnt[2];
      send(2, mk(2, 9'h055, 1'b0, 1'b0), 4);
      @(posedge sys_clk);
      #3 sys_rst_n = 1'b0;
      #1;
      chk("mrst_data", d2, 0);
      chk("mrst_vld", vld[2], 0);
      chk("mrst_busy", bz[2], 0);
      chk("mrst_flags", {pe[2], fe[2], bd[2]}, 0);
      rx_l[2] = 1'b1;
      clk_n(3);
      sys_rst_n = 1'b1;
      clk_n(3 * BIT[2]);
      chk("mrst_no_vld", vld_cnt[2] - vc, 0);
      f = mk(2, 9'h02C, 1'b0, 1'b0);
      q.push_back(model(2, f));
      send(2, f, flen(2));
      idle(2, 2);
      drain(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
